ram8_stream_reader: RTL and testbench
=====================================

# ram8_stream_reader

Sequential read-side engine for the 8x16 `RAM8` store. It is the counterpart of the blocks that write operands and products into `RAM8`, such as the multiplier, which stores operands at addresses 0–1 and the low/high product halves at addresses 2–3. On a start request it walks a run of consecutive addresses, modulo 8, and drives the `RAM8` enable, read and address pins. It captures each 16-bit word and presents it on a valid/ready output stream with a last marker.

## Interface
Parameters: none.

- `clk` in 1: single clock; all state changes on the rising edge.
- `re` in 1: reset; asynchronous, active-low.
- `start` in 1: request a read run; sampled only in IDLE.
- `base` in 3: first address of the run; latched on accepted `start`.
- `count` in 4: number of words to read, 0–15; latched on accepted `start`.
- `ram_e` out 1: `RAM8` enable.
- `ram_r` out 1: `RAM8` read strobe.
- `ram_w` out 1: `RAM8` write strobe; tied to 0.
- `ram_addr` out 3: `RAM8` address.
- `ram_dout` in 16: `RAM8` read data; combinational from `ram_addr`.
- `out_data` out 16: captured word.
- `out_valid` out 1: `out_data` is valid.
- `out_ready` in 1: downstream accepts the word.
- `out_last` out 1: current beat is the final word of the run.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when a run completes.

## Operation
- States are IDLE, SETUP, CAPT, SEND and DONE.
- **IDLE:**
  - `start`=1 and `count`≠0: latch `cur`←`base` and `rem`←`count`, then go to SETUP.
  - `start`=1 and `count`=0: go to DONE without issuing any reads.
  - `start` is ignored in every other state.
- **SETUP:** drive `ram_addr`=`cur`, `ram_e`=1, `ram_r`=1. Go to CAPT.
- **CAPT:** keep the same `ram_addr`, `ram_e` and `ram_r`. Register `ram_dout` into `out_data`. Set `out_last`=(`rem`==1). Go to SEND.
- **SEND:**
  - Assert `out_valid`. Deassert `ram_e` and `ram_r`.
  - `out_data`, `out_last` and `ram_addr` stay stable until the handshake (`out_valid`&&`out_ready` at a rising edge).
  - On handshake with `rem`==1: go to DONE.
  - On handshake otherwise: `cur`←`cur`+1 (3-bit wrap, 7→0), `rem`←`rem`−1, go to SETUP.
- **DONE:** pulse `done`=1 for one cycle, then go to IDLE.
- **Wrap-around:** `count` > 8 rereads addresses in order. Example: `base`=5, `count`=10 reads 5,6,7,0,1,2,3,4,5,6.
- **Reset values:** every output is 0, `out_data`=16'h0000, state is IDLE.
- **Reset mid-run:** the run is aborted; no `done` pulse is issued.

## Timing
- **Start to first beat:** `start` accepted at edge 0; SETUP in cycle 1; CAPT in cycle 2; `out_valid` high in cycle 3.
- **Throughput:** 3 cycles per word with `out_ready` held high.
- **Completion:** `done` is high in the cycle after the final handshake; `busy` falls in the following cycle.
- **`count`=0:** `done` is high in the cycle after `start`, with no `out_valid` and no `ram_r`.
- **Read timing:** `ram_addr` is stable for two full cycles (SETUP, CAPT) before capture, which covers the `RAM8` decoder/mux settle time.

## Configuration
- Macro: `RAM8_READER_PAIR32_EN`.
- **Defined:**
  - Adds outputs `pair32` (32 bits) and `pair32_valid` (1 bit).
  - Beats are paired by index within a run: beat 2j is the low half, beat 2j+1 is the high half.
  - On the handshake of each odd-index beat, `pair32`←{high, low} and `pair32_valid` pulses one cycle in the following cycle.
  - An unpaired trailing low word (odd `count`) is discarded; `pair32` keeps its old value.
  - `pair32` resets to 0.
- **Undefined:** neither port exists and no pairing logic is generated.

## Test plan
- **Reset:** `re`=0 with random inputs → all outputs 0, `busy`=0; after release, idle until `start`.
- **Product readback:** preload addr2=16'h5678 and addr3=16'h1234; `base`=2, `count`=2, `out_ready`=1 → beats 5678 then 1234 (`out_last` on the second), `done` one cycle later. With the macro defined, `pair32`=32'h12345678 and `pair32_valid` pulses.
- **Backpressure:** hold `out_ready`=0 for 5 cycles in SEND → `out_valid`, `out_data` and `ram_addr` stable; `ram_r`=0; no advance until `out_ready`=1.
- **Wrap-around:** `base`=6, `count`=4 → `ram_addr` sequence 6,7,0,1 with matching stored data; `out_last` only on the 4th beat.
- **Empty run:** `count`=0 → `done` in the cycle after `start`; `out_valid` never asserted.
- **Abort and restart:** drive `re`=0 during SEND → `out_valid` drops to 0 immediately and no `done` is issued; after release, a new run `base`=0, `count`=1 completes normally.

Source files
------------

// File: rtl/ram8_stream_reader.sv
// ram8_stream_reader: sequential read engine for the 8x16 RAM8 store.
// Walks `count` consecutive addresses (mod 8) from `base`, holding each
// address for two cycles before capture. Each captured word goes out on a
// valid/ready stream with a last marker.
// Optional feature macro: RAM8_READER_PAIR32_EN adds 32-bit beat pairing
// (pair32 / pair32_valid).
module ram8_stream_reader (
  input  logic        clk,
  input  logic        re,
  input  logic        start,
  input  logic [2:0]  base,
  input  logic [3:0]  count,
  output logic        ram_e,
  output logic        ram_r,
  output logic        ram_w,
  output logic [2:0]  ram_addr,
  input  logic [15:0] ram_dout,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        busy,
  output logic        done
`ifdef RAM8_READER_PAIR32_EN
  ,
  output logic [31:0] pair32,
  output logic        pair32_valid
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_CAPT,
    S_SEND,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cur_q, cur_d;
  logic [3:0]  rem_q, rem_d;
  logic [15:0] data_q, data_d;
  logic        last_q, last_d;
  logic        hs;

  assign hs = (state_q == S_SEND) && out_ready;

  // State and datapath registers; reset aborts any run in progress.
  always_ff @(posedge clk or negedge re) begin
    if (!re) begin
      state_q <= S_IDLE;
      cur_q   <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  // Next-state, datapath updates and RAM8 / stream output decode.
  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    rem_d     = rem_q;
    data_d    = data_q;
    last_d    = last_q;
    ram_e     = 1'b0;
    ram_r     = 1'b0;
    ram_w     = 1'b0;
    ram_addr  = cur_q;
    out_data  = data_q;
    out_valid = 1'b0;
    out_last  = 1'b0;
    busy      = (state_q != S_IDLE);
    done      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (count != 4'd0) begin
            cur_d   = base;
            rem_d   = count;
            state_d = S_SETUP;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_SETUP: begin
        ram_e   = 1'b1;
        ram_r   = 1'b1;
        state_d = S_CAPT;
      end
      S_CAPT: begin
        ram_e   = 1'b1;
        ram_r   = 1'b1;
        data_d  = ram_dout;
        last_d  = (rem_q == 4'd1);
        state_d = S_SEND;
      end
      S_SEND: begin
        out_valid = 1'b1;
        out_last  = last_q;
        if (out_ready) begin
          if (rem_q == 4'd1) begin
            state_d = S_DONE;
          end else begin
            cur_d   = cur_q + 3'd1;
            rem_d   = rem_q - 4'd1;
            state_d = S_SETUP;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef RAM8_READER_PAIR32_EN
  logic        pidx_q, pidx_d;
  logic [15:0] low_q, low_d;
  logic [31:0] pair_q, pair_d;
  logic        pvld_q, pvld_d;

  // Pair tracking: even-index beats are held as the low half, odd-index
  // beats complete the pair. A trailing unpaired low word is simply dropped.
  always_comb begin
    pidx_d = pidx_q;
    low_d  = low_q;
    pair_d = pair_q;
    pvld_d = 1'b0;
    if (state_q == S_IDLE && start) begin
      pidx_d = 1'b0;
    end else if (hs) begin
      pidx_d = ~pidx_q;
      if (pidx_q) begin
        pair_d = {data_q, low_q};
        pvld_d = 1'b1;
      end else begin
        low_d = data_q;
      end
    end
  end

  // Pairing registers.
  always_ff @(posedge clk or negedge re) begin
    if (!re) begin
      pidx_q <= 1'b0;
      low_q  <= '0;
      pair_q <= '0;
      pvld_q <= 1'b0;
    end else begin
      pidx_q <= pidx_d;
      low_q  <= low_d;
      pair_q <= pair_d;
      pvld_q <= pvld_d;
    end
  end

  assign pair32       = pair_q;
  assign pair32_valid = pvld_q;
`endif

endmodule

// File: tb/tb_ram8_stream_reader.sv
// Directed testbench for ram8_stream_reader with a combinational RAM8 model.
module tb_ram8_stream_reader;

  logic        clk = 1'b0;
  logic        re;
  logic        start;
  logic [2:0]  base;
  logic [3:0]  count;
  logic        ram_e, ram_r, ram_w;
  logic [2:0]  ram_addr;
  logic [15:0] ram_dout;
  logic [15:0] out_data;
  logic        out_valid, out_ready, out_last, busy, done;
`ifdef RAM8_READER_PAIR32_EN
  logic [31:0] pair32;
  logic        pair32_valid;
`endif

  logic [15:0] mem [8];
  int passed = 0;
  int total  = 0;

  assign ram_dout = mem[ram_addr];

  always #5 clk = ~clk;

  ram8_stream_reader dut (
    .clk(clk), .re(re), .start(start), .base(base), .count(count),
    .ram_e(ram_e), .ram_r(ram_r), .ram_w(ram_w), .ram_addr(ram_addr),
    .ram_dout(ram_dout), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy), .done(done)
`ifdef RAM8_READER_PAIR32_EN
    , .pair32(pair32), .pair32_valid(pair32_valid)
`endif
  );

  // Accept a run at the next edge; returns at the negedge of cycle 1.
  task automatic launch(input logic [2:0] b, input logic [3:0] c);
    @(negedge clk);
    start = 1'b1; base = b; count = c;
    @(negedge clk);
    start = 1'b0; base = $urandom; count = $urandom;
  endtask

  task automatic test_reset;
    re = 1'b0;
    start = $urandom; base = $urandom; count = $urandom; out_ready = $urandom;
    repeat (2) @(negedge clk);
    total++; if ({ram_e, ram_r, ram_w} !== 3'b000) $display("FAIL reset_ram_ctl got=%b exp=000", {ram_e, ram_r, ram_w}); else passed++;
    total++; if (ram_addr !== 3'd0) $display("FAIL reset_addr got=%0d exp=0", ram_addr); else passed++;
    total++; if (out_data !== 16'h0000) $display("FAIL reset_data got=%h exp=0000", out_data); else passed++;
    total++; if ({out_valid, out_last} !== 2'b00) $display("FAIL reset_stream got=%b exp=00", {out_valid, out_last}); else passed++;
    total++; if ({busy, done} !== 2'b00) $display("FAIL reset_status got=%b exp=00", {busy, done}); else passed++;
`ifdef RAM8_READER_PAIR32_EN
    total++; if ({pair32, pair32_valid} !== 33'd0) $display("FAIL reset_pair got=%h exp=0", {pair32, pair32_valid}); else passed++;
`endif
    start = 1'b0; out_ready = 1'b0;
    re = 1'b1;
    repeat (3) @(negedge clk);
    total++; if ({busy, ram_e, out_valid} !== 3'b000) $display("FAIL idle_after_reset got=%b exp=000", {busy, ram_e, out_valid}); else passed++;
  endtask

  task automatic test_readback;
    out_ready = 1'b1;
    launch(3'd2, 4'd2);
    // cycle 1: SETUP
    total++; if ({ram_e, ram_r, ram_addr, out_valid} !== {2'b11, 3'd2, 1'b0}) $display("FAIL rb_setup got=%b exp=110100", {ram_e, ram_r, ram_addr, out_valid}); else passed++;
    @(negedge clk); // cycle 2: CAPT
    total++; if ({ram_r, ram_addr, out_valid} !== {1'b1, 3'd2, 1'b0}) $display("FAIL rb_capt got=%b exp=10100", {ram_r, ram_addr, out_valid}); else passed++;
    @(negedge clk); // cycle 3: first beat
    total++; if ({out_valid, out_last, ram_r} !== 3'b100) $display("FAIL rb_beat0_ctl got=%b exp=100", {out_valid, out_last, ram_r}); else passed++;
    total++; if (out_data !== 16'h5678) $display("FAIL rb_beat0_data got=%h exp=5678", out_data); else passed++;
    @(negedge clk); // cycle 4: SETUP addr 3
    total++; if ({ram_r, ram_addr, out_valid} !== {1'b1, 3'd3, 1'b0}) $display("FAIL rb_setup1 got=%b exp=10110", {ram_r, ram_addr, out_valid}); else passed++;
    repeat (2) @(negedge clk); // cycle 6: second beat
    total++; if ({out_valid, out_last} !== 2'b11) $display("FAIL rb_beat1_ctl got=%b exp=11", {out_valid, out_last}); else passed++;
    total++; if (out_data !== 16'h1234) $display("FAIL rb_beat1_data got=%h exp=1234", out_data); else passed++;
    total++; if (done !== 1'b0) $display("FAIL rb_done_early got=%b exp=0", done); else passed++;
    @(negedge clk); // cycle 7: DONE
    total++; if ({done, busy, out_valid} !== 3'b110) $display("FAIL rb_done got=%b exp=110", {done, busy, out_valid}); else passed++;
`ifdef RAM8_READER_PAIR32_EN
    total++; if (pair32_valid !== 1'b1) $display("FAIL rb_pair_valid got=%b exp=1", pair32_valid); else passed++;
    total++; if (pair32 !== 32'h12345678) $display("FAIL rb_pair32 got=%h exp=12345678", pair32); else passed++;
`endif
    @(negedge clk);
    total++; if ({done, busy} !== 2'b00) $display("FAIL rb_idle got=%b exp=00", {done, busy}); else passed++;
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    launch(3'd1, 4'd1);
    repeat (2) @(negedge clk); // SEND
    for (int i = 0; i < 5; i++) begin
      total++; if ({out_valid, ram_r, ram_e, ram_addr} !== {3'b100, 3'd1}) $display("FAIL bp_ctl[%0d] got=%b exp=100001", i, {out_valid, ram_r, ram_e, ram_addr}); else passed++;
      total++; if (out_data !== 16'hBEEF) $display("FAIL bp_data[%0d] got=%h exp=beef", i, out_data); else passed++;
      total++; if (done !== 1'b0) $display("FAIL bp_noadv[%0d] got=%b exp=0", i, done); else passed++;
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    total++; if ({done, out_valid} !== 2'b10) $display("FAIL bp_release got=%b exp=10", {done, out_valid}); else passed++;
  endtask

  task automatic test_wrap;
    logic [2:0] exp_addr [4];
    int n;
    exp_addr[0] = 3'd6; exp_addr[1] = 3'd7; exp_addr[2] = 3'd0; exp_addr[3] = 3'd1;
    out_ready = 1'b1;
    launch(3'd6, 4'd4);
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (out_valid !== 1'b1 && n < 8) begin
        @(negedge clk);
        n++;
      end
      total++; if (out_valid !== 1'b1) $display("FAIL wrap_timeout[%0d] got=%b exp=1", k, out_valid); else passed++;
      total++; if (ram_addr !== exp_addr[k]) $display("FAIL wrap_addr[%0d] got=%0d exp=%0d", k, ram_addr, exp_addr[k]); else passed++;
      total++; if (out_data !== mem[exp_addr[k]]) $display("FAIL wrap_data[%0d] got=%h exp=%h", k, out_data, mem[exp_addr[k]]); else passed++;
      total++; if (out_last !== (k == 3)) $display("FAIL wrap_last[%0d] got=%b exp=%b", k, out_last, (k == 3)); else passed++;
      @(negedge clk);
    end
    total++; if (done !== 1'b1) $display("FAIL wrap_done got=%b exp=1", done); else passed++;
    @(negedge clk);
  endtask

  task automatic test_empty;
    out_ready = 1'b1;
    launch(3'd4, 4'd0);
    total++; if ({done, out_valid, ram_r, ram_e} !== 4'b1000) $display("FAIL empty_done got=%b exp=1000", {done, out_valid, ram_r, ram_e}); else passed++;
    @(negedge clk);
    total++; if ({done, busy, out_valid} !== 3'b000) $display("FAIL empty_idle got=%b exp=000", {done, busy, out_valid}); else passed++;
  endtask

  task automatic test_abort_restart;
    out_ready = 1'b0;
    launch(3'd3, 4'd2);
    repeat (2) @(negedge clk); // SEND
    total++; if (out_valid !== 1'b1) $display("FAIL abort_send got=%b exp=1", out_valid); else passed++;
    #2 re = 1'b0;
    #1;
    total++; if ({out_valid, busy} !== 2'b00) $display("FAIL abort_immediate got=%b exp=00", {out_valid, busy}); else passed++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (done !== 1'b0) $display("FAIL abort_nodone[%0d] got=%b exp=0", i, done); else passed++;
    end
    re = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    total++; if ({done, busy} !== 2'b00) $display("FAIL abort_post_release got=%b exp=00", {done, busy}); else passed++;
    launch(3'd0, 4'd1);
    repeat (2) @(negedge clk);
    total++; if ({out_valid, out_last, ram_addr} !== {2'b11, 3'd0}) $display("FAIL restart_ctl got=%b exp=11000", {out_valid, out_last, ram_addr}); else passed++;
    total++; if (out_data !== 16'hC0DE) $display("FAIL restart_data got=%h exp=c0de", out_data); else passed++;
    @(negedge clk);
    total++; if (done !== 1'b1) $display("FAIL restart_done got=%b exp=1", done); else passed++;
`ifdef RAM8_READER_PAIR32_EN
    total++; if ({pair32_valid, pair32} !== {1'b0, 32'd0}) $display("FAIL restart_pair got=%h exp=0", {pair32_valid, pair32}); else passed++;
`endif
    @(negedge clk);
  endtask

  initial begin
    mem[0] = 16'hC0DE; mem[1] = 16'hBEEF; mem[2] = 16'h5678; mem[3] = 16'h1234;
    mem[4] = 16'h4444; mem[5] = 16'h5555; mem[6] = 16'hA6A6; mem[7] = 16'hA7A7;
    test_reset();
    test_readback();
    test_backpressure();
    mem[0] = 16'hA0A0; mem[1] = 16'hA1A1;
    test_wrap();
    test_empty();
    mem[0] = 16'hC0DE;
    test_abort_restart();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
